// File: rtl/video_timing.sv
// Raster timing generator: H/V pixel counters, blanking, sync, display enable and vblank IRQ.
// Define VTIMING_VBL_IRQ_EN to build the vblank interrupt handshake (VBL_IRQ / IRQ_OVR).
module video_timing #(
  parameter int H_TOTAL  = 384,
  parameter int H_ACTIVE = 256,
  parameter int HS_START = 288,
  parameter int HS_LEN   = 32,
  parameter int V_TOTAL  = 264,
  parameter int V_ACTIVE = 224,
  parameter int VS_START = 240,
  parameter int VS_LEN   = 8
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic       CE_PIX,
  input  logic       IRQ_ACK,
  output logic [8:0] HCOUNT,
  output logic [8:0] VCOUNT,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       DISP_EN,
  output logic       HSYNC_N,
  output logic       VSYNC_N,
  output logic       VBL_START,
  output logic       VBL_IRQ,
  output logic       IRQ_OVR
);

  // Reject geometries the 9-bit counters or the sync decode cannot represent.
  if (H_TOTAL > 512 || V_TOTAL > 512 || H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_total
    $error("video_timing: H_TOTAL/V_TOTAL must be in 2..512");
  end
  if (HS_START + HS_LEN > H_TOTAL || VS_START + VS_LEN > V_TOTAL) begin : g_bad_sync
    $error("video_timing: sync pulse extends past end of line/frame");
  end
  if (H_ACTIVE < 1 || H_ACTIVE > H_TOTAL || V_ACTIVE < 1 || V_ACTIVE >= V_TOTAL) begin : g_bad_active
    $error("video_timing: active region out of range");
  end

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);

  logic [8:0] h_nxt;
  logic [8:0] v_nxt;
  logic       hblank_nxt;
  logic       vblank_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       vbl_set;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    h_nxt = HCOUNT;
    v_nxt = VCOUNT;
    if (CE_PIX) begin
      if (HCOUNT == H_LAST) begin
        h_nxt = '0;
        v_nxt = (VCOUNT == V_LAST) ? '0 : VCOUNT + 9'd1;
      end else begin
        h_nxt = HCOUNT + 9'd1;
      end
    end
  end

  // Decode from the next counter values so the registered flags line up with HCOUNT/VCOUNT.
  assign hblank_nxt = int'(h_nxt) >= H_ACTIVE;
  assign vblank_nxt = int'(v_nxt) >= V_ACTIVE;
  assign hsync_nxt  = int'(h_nxt) >= HS_START && int'(h_nxt) < HS_START + HS_LEN;
  assign vsync_nxt  = int'(v_nxt) >= VS_START && int'(v_nxt) < VS_START + VS_LEN;
  // Qualified by CE_PIX so a stalled raster parked at (0,V_ACTIVE) cannot re-fire.
  assign vbl_set    = CE_PIX && h_nxt == '0 && v_nxt == V_ACT;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      HCOUNT    <= '0;
      VCOUNT    <= '0;
      HBLANK    <= 1'b0;
      VBLANK    <= 1'b0;
      DISP_EN   <= 1'b1;
      HSYNC_N   <= 1'b1;
      VSYNC_N   <= 1'b1;
      VBL_START <= 1'b0;
    end else begin
      HCOUNT    <= h_nxt;
      VCOUNT    <= v_nxt;
      HBLANK    <= hblank_nxt;
      VBLANK    <= vblank_nxt;
      DISP_EN   <= !hblank_nxt && !vblank_nxt;
      HSYNC_N   <= !hsync_nxt;
      VSYNC_N   <= !vsync_nxt;
      VBL_START <= vbl_set;
    end
  end

`ifdef VTIMING_VBL_IRQ_EN
  typedef enum logic {
    IRQ_IDLE,
    IRQ_PENDING
  } irq_state_t;

  irq_state_t irq_state;
  logic       irq_ovr;

  // A new vblank always wins over a same-cycle acknowledge.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      irq_state <= IRQ_IDLE;
      irq_ovr   <= 1'b0;
    end else if (vbl_set) begin
      if (irq_state == IRQ_PENDING && !IRQ_ACK) irq_ovr <= 1'b1;
      irq_state <= IRQ_PENDING;
    end else if (IRQ_ACK) begin
      irq_state <= IRQ_IDLE;
      irq_ovr   <= 1'b0;
    end
  end

  assign VBL_IRQ = irq_state == IRQ_PENDING;
  assign IRQ_OVR = irq_ovr;
`else
  logic irq_ack_unused;
  assign irq_ack_unused = IRQ_ACK;
  assign VBL_IRQ        = 1'b0;
  assign IRQ_OVR        = 1'b0;
`endif

endmodule
